// File: rtl/req_ack_pkg.sv
// Shared types and defaults for the 2-phase request/acknowledge receive arbiter.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2
  } ch_state_t;

  localparam int SYNC_DEFAULT = 2;

endpackage

// File: rtl/req_ack_2ph_sync.sv
// Brings one asynchronous 2-phase req into clk_rx and emits a one-cycle pulse per toggle.
module req_ack_2ph_sync #(
  parameter int SYNC = 2
) (
  input  logic clk_rx,
  input  logic rst_b,
  input  logic req_i,
  output logic tgl_o
);

  logic [SYNC-1:0] sync_q;
  logic            hist_q;

  always_ff @(posedge clk_rx or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], req_i};
      hist_q <= sync_q[SYNC-1];
    end
  end

  assign tgl_o = sync_q[SYNC-1] ^ hist_q;

endmodule

// File: rtl/req_ack_2ph_rx_arb.sv
// Multi-channel 2-phase receiver: per-channel IDLE/PEND/BUSY tracking and a
// round-robin arbiter feeding a single registered output word with ready/valid.
module req_ack_2ph_rx_arb
  import req_ack_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int DW   = 16,
  parameter  int SYNC = SYNC_DEFAULT,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk_rx,
  input  logic                   rst_b,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0][DW-1:0] din,
  output logic [NCH-1:0]         ack,
  input  logic [NCH-1:0]         en,
  output logic                   val,
  input  logic                   rdy,
  output logic [DW-1:0]          dout,
  output logic [CW-1:0]          dout_ch,
  output logic [NCH-1:0]         ovr
);

  logic [NCH-1:0] tgl;
  ch_state_t      state_q [NCH];
  ch_state_t      state_d [NCH];
  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic [NCH-1:0] elig;
  logic           val_q;
  logic [DW-1:0]  dout_q;
  logic [CW-1:0]  dout_ch_q;
  logic [CW-1:0]  rr_q, rr_d;
  logic           hs, gnt, gnt_vld;
  logic [CW-1:0]  gnt_idx;
  int             cand;

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    req_ack_2ph_sync #(.SYNC(SYNC)) u_sync (
      .clk_rx (clk_rx),
      .rst_b  (rst_b),
      .req_i  (req[i]),
      .tgl_o  (tgl[i])
    );
  end

  // Round-robin search starting at rr_q; only PEND channels with en set compete.
  always_comb begin
    hs      = val_q && rdy;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int i = 0; i < NCH; i++) elig[i] = (state_q[i] == PEND) && en[i];
    for (int k = 0; k < NCH; k++) begin
      cand = (int'(rr_q) + k) % NCH;
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(cand);
      end
    end
    gnt  = gnt_vld && (!val_q || rdy);
    rr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Toggles outside IDLE are protocol overruns: flagged, never acted upon.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      ack_d[i]   = ack_q[i];
      ovr_d[i]   = ovr_q[i];
      case (state_q[i])
        IDLE: if (tgl[i]) state_d[i] = PEND;
        PEND: begin
          if (tgl[i]) ovr_d[i] = 1'b1;
          if (gnt && gnt_idx == CW'(i)) state_d[i] = BUSY;
        end
        BUSY: begin
          if (tgl[i]) ovr_d[i] = 1'b1;
          if (hs && dout_ch_q == CW'(i)) begin
            state_d[i] = IDLE;
            ack_d[i]   = ~ack_q[i];
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rx or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= IDLE;
      ack_q <= '0;
      ovr_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
      ack_q <= ack_d;
      ovr_q <= ovr_d;
    end
  end

  // Output word register: a grant on the handshake edge keeps val high.
  always_ff @(posedge clk_rx or negedge rst_b) begin
    if (!rst_b) begin
      val_q     <= 1'b0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      rr_q      <= '0;
    end else if (gnt) begin
      val_q     <= 1'b1;
      dout_q    <= din[gnt_idx];
      dout_ch_q <= gnt_idx;
      rr_q      <= rr_d;
    end else if (hs) begin
      val_q     <= 1'b0;
    end
  end

  assign ack     = ack_q;
  assign ovr     = ovr_q;
  assign val     = val_q;
  assign dout    = dout_q;
  assign dout_ch = dout_ch_q;

endmodule
